// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the
// eight-way round-robin mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [N_REQ-1:0] v;
      v = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching ptr, ptr+1, ... modulo 8.
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // rot[k] is the request sitting k places after ptr; the index sum wraps naturally
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign rot[gi] = req[ptr + SEL_W'(gi)];
      end
   endgenerate

   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = SEL_W'(k);
         end
      end
   end

   assign any = |req;
   assign idx = ptr + off;

endmodule

// File: rtl/rr_mux_arbiter8.sv
// Eight-requester round-robin arbiter feeding a registered valid/ready
// output; the granted word is captured at grant time and held until accepted.
module rr_mux_arbiter8
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] data_in,
   output logic [N_REQ-1:0]       ack,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       out_src
);

   arb_state_e       state_q;
   logic [SEL_W-1:0] ptr_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_src_q;
   logic [N_REQ-1:0] ack_q;

   logic [N_REQ-1:0] req_eff;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic [WIDTH-1:0] word [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_word
         assign word[gi] = data_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // The requester just acked may still show req high this cycle; don't re-grant it.
   assign req_eff = req & ~ack_q;

   rr_pick8 u_pick (
      .req (req_eff),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ack_q       <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  out_src_q   <= pick_idx;
                  out_data_q  <= word[pick_idx];
                  out_valid_q <= 1'b1;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  ack_q       <= sel_onehot(out_src_q);
                  ptr_q       <= out_src_q + SEL_W'(1);
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter8.sv
// Scenario bench for rr_mux_arbiter8: expected grants are queued when
// requests are driven and popped as each transfer completes.
module tb_rr_mux_arbiter8;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic [7:0]         req = '0;
   logic [8*WIDTH-1:0] data_in = '0;
   logic [7:0]         ack;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_src;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]       src;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb[$];

   rr_mux_arbiter8 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] word_val(input int i);
      return WIDTH'(8'h11 * i + 5);
   endfunction

   function automatic logic [7:0] bit_of(input logic [2:0] i);
      logic [7:0] one;
      one = 8'd1;
      return one << i;
   endfunction

   task automatic set_word(input int i, input logic [WIDTH-1:0] v);
      data_in[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic load_words();
      for (int i = 0; i < 8; i++) set_word(i, word_val(i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   // Waits (bounded) for out_valid with out_ready=1, records the transfer and the ack cycle.
   task automatic serve_one(input logic [7:0] raise_mask, output bit got,
                            output logic [2:0] src, output logic [WIDTH-1:0] data,
                            output logic [7:0] ack_seen, output logic valid_after,
                            output int waits);
      got = 1'b0;
      waits = 0;
      src = '0;
      data = '0;
      ack_seen = '0;
      valid_after = 1'b1;
      while (!got && waits < 20) begin
         @(negedge clk);
         waits++;
         if (waits == 1) req = req | raise_mask;
         if (out_valid === 1'b1) got = 1'b1;
      end
      if (got) begin
         src = out_src;
         data = out_data;
         @(negedge clk);
         ack_seen = ack;
         valid_after = out_valid;
         req[src] = 1'b0;
         $display("txn src=%0d data=%02h ack=%02h wait=%0d", src, data, ack_seen, waits);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, ack, out_src, out_data} !== '0)
         $display("FAIL reset_state: valid=%b ack=%02h src=%0d data=%02h, required all zero",
                  out_valid, ack, out_src, out_data);
      if ({out_valid, ack, out_src, out_data} !== '0) failures++;
      rst_n = 1'b1;
      req = 8'h00;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || ack !== 8'h00 || out_src !== 3'd0) begin
            failures++;
            $display("FAIL idle_no_req cycle %0d: valid=%b ack=%02h src=%0d, required 0/00/0",
                     c, out_valid, ack, out_src);
         end
      end
   endtask

   task automatic test_two_req();
      bit got; logic [2:0] src; logic [WIDTH-1:0] data; logic [7:0] a; logic va; int w; exp_t e;
      do_reset();
      data_in = '0;
      set_word(2, 8'hA5);
      set_word(5, 8'h3C);
      out_ready = 1'b1;
      req = 8'h24;
      sb.push_back('{3'd2, 8'hA5});
      sb.push_back('{3'd5, 8'h3C});
      for (int n = 0; n < 2; n++) begin
         serve_one(8'h00, got, src, data, a, va, w);
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL two_req timeout grant %0d: out_valid never rose", n);
         end else begin
            e = sb.pop_front();
            checks++;
            if (src !== e.src || data !== e.data || a !== bit_of(e.src) || va !== 1'b0) begin
               failures++;
               $display("FAIL two_req grant %0d: src=%0d data=%02h ack=%02h valid=%b, required src=%0d data=%02h ack=%02h valid=0",
                        n, src, data, a, va, e.src, e.data, bit_of(e.src));
            end
         end
      end
      req = '0;
   endtask

   task automatic test_throughput();
      bit got; logic [2:0] src; logic [WIDTH-1:0] data; logic [7:0] a; logic va; int w; exp_t e;
      logic [7:0] raise;
      do_reset();
      load_words();
      out_ready = 1'b1;
      req = 8'hFF;
      for (int i = 0; i < 9; i++) sb.push_back('{3'(i % 8), word_val(i % 8)});
      raise = 8'h00;
      for (int n = 0; n < 9; n++) begin
         serve_one(raise, got, src, data, a, va, w);
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL rotate timeout grant %0d: out_valid never rose", n);
         end else begin
            e = sb.pop_front();
            checks++;
            if (src !== e.src || data !== e.data || a !== bit_of(e.src) || w !== 1) begin
               failures++;
               $display("FAIL rotate grant %0d: src=%0d data=%02h ack=%02h wait=%0d, required src=%0d data=%02h ack=%02h wait=1",
                        n, src, data, a, w, e.src, e.data, bit_of(e.src));
            end
            raise = bit_of(src);
         end
      end
      req = '0;
   endtask

   task automatic test_hold();
      bit got; exp_t e;
      do_reset();
      load_words();
      set_word(3, 8'h77);
      out_ready = 1'b0;
      req = 8'h08;
      sb.push_back('{3'd3, 8'h77});
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL hold timeout: out_valid never rose for requester 3");
      end
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         set_word(3, WIDTH'(8'h88 + c));
         req = 8'h08 | 8'(8'h15 << c);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data || ack !== 8'h00) begin
            failures++;
            $display("FAIL hold cycle %0d: valid=%b src=%0d data=%02h ack=%02h, required 1/%0d/%02h/00",
                     c, out_valid, out_src, out_data, ack, e.src, e.data);
         end
      end
      req = 8'h08;
      out_ready = 1'b1;
      @(negedge clk);
      $display("txn src=3 data=77 ack=%02h after stall", ack);
      checks++;
      if (ack !== 8'h08 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_release: ack=%02h valid=%b, required ack=08 valid=0", ack, out_valid);
      end
      req = 8'h00;
      @(negedge clk);
      checks++;
      if (ack !== 8'h00) begin
         failures++;
         $display("FAIL hold_ack_pulse: ack=%02h one cycle later, required 00", ack);
      end
   endtask

   task automatic test_wrap();
      bit got; logic [2:0] src; logic [WIDTH-1:0] data; logic [7:0] a; logic va; int w; exp_t e;
      do_reset();
      load_words();
      out_ready = 1'b1;
      req = 8'h40;
      sb.push_back('{3'd6, word_val(6)});
      sb.push_back('{3'd7, word_val(7)});
      sb.push_back('{3'd0, word_val(0)});
      for (int n = 0; n < 3; n++) begin
         serve_one(8'h00, got, src, data, a, va, w);
         if (n == 0) req = 8'h81;
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL wrap timeout grant %0d: out_valid never rose", n);
         end else begin
            e = sb.pop_front();
            checks++;
            if (src !== e.src || data !== e.data || a !== bit_of(e.src)) begin
               failures++;
               $display("FAIL wrap grant %0d: src=%0d data=%02h ack=%02h, required src=%0d data=%02h ack=%02h",
                        n, src, data, a, e.src, e.data, bit_of(e.src));
            end
         end
      end
      req = '0;
   endtask

   task automatic test_reset_busy();
      bit got; logic [2:0] src; logic [WIDTH-1:0] data; logic [7:0] a; logic va; int w; exp_t e;
      do_reset();
      load_words();
      out_ready = 1'b1;
      req = 8'h04;
      sb.push_back('{3'd2, word_val(2)});
      serve_one(8'h00, got, src, data, a, va, w);
      e = sb.pop_front();
      checks++;
      if (!got || src !== e.src || a !== 8'h04) begin
         failures++;
         $display("FAIL rstbusy_setup: got=%b src=%0d ack=%02h, required got=1 src=2 ack=04", got, src, a);
      end
      out_ready = 1'b0;
      req = 8'h10;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || out_src !== 3'd4) begin
         failures++;
         $display("FAIL rstbusy_grant: got=%b src=%0d, required got=1 src=4", got, out_src);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ack !== 8'h00 || out_src !== 3'd0 || out_data !== '0) begin
         failures++;
         $display("FAIL rstbusy_async: valid=%b ack=%02h src=%0d data=%02h, required all zero",
                  out_valid, ack, out_src, out_data);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || ack !== 8'h00) begin
         failures++;
         $display("FAIL rstbusy_hold: valid=%b ack=%02h during reset, required 0/00", out_valid, ack);
      end
      @(negedge clk);
      req = 8'h11;
      rst_n = 1'b1;
      sb.push_back('{3'd0, word_val(0)});
      serve_one(8'h00, got, src, data, a, va, w);
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL rstbusy_after timeout: out_valid never rose");
      end else begin
         e = sb.pop_front();
         checks++;
         if (src !== e.src || data !== e.data || a !== bit_of(e.src) || w !== 1) begin
            failures++;
            $display("FAIL rstbusy_after: src=%0d data=%02h ack=%02h wait=%0d, required src=%0d data=%02h ack=%02h wait=1",
                     src, data, a, w, e.src, e.data, bit_of(e.src));
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_two_req();
      test_throughput();
      test_hold();
      test_wrap();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter8.md
RR_MUX_ARBITER8 -- requirements
Module: rr_mux_arbiter8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of each requester data word.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 SHALL have port req, input, 8 bits, meaning that requester i has a word to transfer when req[i]=1.
REQ-005 SHALL have port data_in, input, 8*WIDTH bits, meaning requester i's word on bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port ack, output, 8 bits, where ack[i] pulses for one cycle when requester i's word is accepted downstream.
REQ-007 SHALL have port out_valid, output, 1 bit, meaning out_data and out_src are valid.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning downstream accepts when out_valid=1 and out_ready=1.
REQ-009 SHALL have port out_data, output, WIDTH bits, meaning the granted requester's captured word.
REQ-010 SHALL have port out_src, output, 3 bits, meaning the index of the granted requester (the mux select).

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-012 In IDLE with req=0, SHALL stay in IDLE with out_valid=0.
REQ-013 In IDLE with req!=0, SHALL select the first set req bit searching ptr, ptr+1, ... mod 8; load out_src with that index, out_data with data_in[index], and set out_valid=1; enter BUSY on the same edge (latency req->out_valid is 1 cycle).
REQ-014 In BUSY, out_data and out_src SHALL be held stable; changes on data_in or req SHALL NOT affect them.
REQ-015 In BUSY with out_ready=0, SHALL remain in BUSY with out_valid=1 for an unbounded time.
REQ-016 In BUSY with out_ready=1, SHALL on the next edge clear out_valid, pulse ack[out_src] for exactly that one cycle, set ptr to out_src+1 (7 wraps to 0), and return to IDLE.
REQ-017 ack SHALL be one-hot or zero, never more than one bit set.
REQ-018 Maximum throughput SHALL be one transfer per 2 cycles; IDLE SHALL NOT grant in the cycle ack is high.
REQ-019 Requesters SHALL be required to hold req until ack; req dropped while BUSY SHALL NOT abort the transfer; in the ack cycle the arbiter SHALL ignore req[out_src].
REQ-020 With all 8 requesting continuously, grants SHALL rotate 0,1,...,7,0 (starvation-free, each requester served within 8 grants).
REQ-021 out_valid SHALL be driven only from a register (no combinational path from req or out_ready).

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, ptr=0, out_valid=0, out_data=0, out_src=0, ack=0.
REQ-023 Reset asserted while in BUSY SHALL discard the pending transfer with no ack issued.
REQ-024 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge with req!=0.

Structure
REQ-025 Package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3 and the FSM state typedef (IDLE, BUSY).
REQ-026 Sub-module rr_pick8 SHALL be a combinational rotating-priority picker: inputs req[7:0] and ptr[2:0]; outputs any and idx[2:0].

Verification
REQ-027 Reset, then req=8'h00 for 10 cycles -> out_valid=0, ack=0, out_src=0 throughout.
REQ-028 After reset, req=8'h24 with data words 2=0xA5, 5=0x3C and out_ready=1 -> first grant out_src=2, out_data=0xA5, ack=8'h04; next grant out_src=5, out_data=0x3C, ack=8'h20.
REQ-029 req=8'hFF held with requesters dropping req on ack and re-raising it, out_ready=1 -> grants 0..7 then 0, one per 2 cycles.
REQ-030 Grant to requester 3, out_ready=0 for 5 cycles while data_in word 3 changes -> out_valid stays 1, out_data unchanged, ack=0; out_ready=1 -> ack=8'h08 one cycle.
REQ-031 ptr=7 after granting 6, req=8'h81 -> grant 7, then 0 (wrap-around).
REQ-032 rst_n pulsed low while BUSY -> out_valid=0 immediately, no ack, and the next grant starts search at index 0.
